// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB-to-FIFO bridge: register tags/offsets,
// STATUS bit positions and the APB transfer state encoding.
package apb_fifo_pkg;

    localparam int unsigned TAG_CONFIG  = 0;
    localparam int unsigned TAG_DATA    = 1;
    localparam int unsigned TAG_STATUS  = 2;
    localparam int unsigned TAG_CHANNEL = 3;

    localparam int unsigned OFF_CONFIG  = 0;
    localparam int unsigned OFF_DATA    = 1;
    localparam int unsigned OFF_STATUS  = 2;
    localparam int unsigned OFF_CHANNEL = 3;

    localparam int unsigned STAT_CBF = 8;
    localparam int unsigned STAT_CBE = 9;
    localparam int unsigned STAT_RDV = 10;
    localparam int unsigned STAT_OVR = 11;
    localparam int unsigned STAT_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_fifo_bridge_if.sv
// APB3 bus bundle between the register-bus master and the FIFO bridge slave.
interface apb_fifo_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (output paddr, psel, penable, pwrite, pwdata,
                    input  pready, prdata, pslverr);
    modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                    output pready, prdata, pslverr);
endinterface

// File: rtl/apb_fifo_regmirror.sv
// Pops rx FIFO entries (at most one per two cycles) into mirrored registers
// and tracks the DATA-valid / overrun flags.
module apb_fifo_regmirror
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int CFG_W  = 16,
    parameter int CH_W   = 2
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    fifo_read_empty,
    input  logic [TAG_W+DATA_W-1:0] fifo_read_data,
    input  logic                    fifo_write_full,
    input  logic                    fifo_write_empty,
    input  logic                    clr_rdv,
    input  logic                    clr_ovr,
    output logic                    fifo_read_inc,
    output logic [CFG_W-1:0]        cfg_q,
    output logic [DATA_W-1:0]       data_q,
    output logic [STAT_W-1:0]       status_q,
    output logic [CH_W-1:0]         chan_q
);
    logic              pop;
    logic              pop_data;
    logic [TAG_W-1:0]  rx_tag;
    logic [DATA_W-1:0] rx_pay;
    logic [7:0]        core_q;
    logic              cbf_q, cbe_q, rdv_q, ovr_q;

    assign rx_tag   = fifo_read_data[TAG_W+DATA_W-1 -: TAG_W];
    assign rx_pay   = fifo_read_data[DATA_W-1:0];
    assign pop      = !fifo_read_empty && !fifo_read_inc;
    assign pop_data = pop && (rx_tag == TAG_W'(TAG_DATA));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            fifo_read_inc <= 1'b0;
            cfg_q         <= '0;
            data_q        <= '0;
            core_q        <= '0;
            chan_q        <= '0;
            cbf_q         <= 1'b0;
            cbe_q         <= 1'b0;
            rdv_q         <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            fifo_read_inc <= pop;
            cbf_q         <= fifo_write_full;
            cbe_q         <= fifo_write_empty;
            if (pop) begin
                case (rx_tag)
                    TAG_W'(TAG_CONFIG):  cfg_q  <= rx_pay[CFG_W-1:0];
                    TAG_W'(TAG_DATA):    data_q <= rx_pay;
                    TAG_W'(TAG_STATUS):  core_q <= rx_pay[7:0];
                    TAG_W'(TAG_CHANNEL): chan_q <= rx_pay[CH_W-1:0];
                    default: ;
                endcase
            end
            // A pop landing on the same edge as an APB read-clear wins.
            if (pop_data)     rdv_q <= 1'b1;
            else if (clr_rdv) rdv_q <= 1'b0;
            if (pop_data && rdv_q) ovr_q <= 1'b1;
            else if (clr_ovr)      ovr_q <= 1'b0;
        end
    end

    always_comb begin
        status_q           = '0;
        status_q[7:0]      = core_q;
        status_q[STAT_CBF] = cbf_q;
        status_q[STAT_CBE] = cbe_q;
        status_q[STAT_RDV] = rdv_q;
        status_q[STAT_OVR] = ovr_q;
    end
endmodule

// File: rtl/apb_fifo_bridge.sv
// APB3 slave turning register writes into tagged tx FIFO entries and serving
// reads from registers mirrored off the rx FIFO.
module apb_fifo_bridge
    import apb_fifo_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 2,
    parameter int BASE_ADDR = 1,
    parameter int CFG_W     = 16,
    parameter int CH_W      = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    apb_fifo_bridge_if.slave        apb,
    input  logic                    fifo_write_full,
    input  logic                    fifo_write_empty,
    output logic [TAG_W+DATA_W-1:0] fifo_write_data,
    output logic                    fifo_write_inc,
    input  logic                    fifo_read_empty,
    input  logic [TAG_W+DATA_W-1:0] fifo_read_data,
    output logic                    fifo_read_inc,
    output logic                    irq
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_t              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    pready_n, pslverr_n, inc_n;
    logic [DATA_W-1:0]       prdata_n, rd_val;
    logic [TAG_W+DATA_W-1:0] wdata_n, push_word;
    logic                    access, in_range, bad;
    logic [ADDR_W-1:0]       off;
    logic                    clr_rdv, clr_ovr;
    logic [CFG_W-1:0]        cfg_q;
    logic [DATA_W-1:0]       data_q;
    logic [STAT_W-1:0]       status_q;
    logic [CH_W-1:0]         chan_q;

    apb_fifo_regmirror #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .CFG_W(CFG_W), .CH_W(CH_W)
    ) u_mirror (
        .pclk            (pclk),
        .preset_n        (preset_n),
        .fifo_read_empty (fifo_read_empty),
        .fifo_read_data  (fifo_read_data),
        .fifo_write_full (fifo_write_full),
        .fifo_write_empty(fifo_write_empty),
        .clr_rdv         (clr_rdv),
        .clr_ovr         (clr_ovr),
        .fifo_read_inc   (fifo_read_inc),
        .cfg_q           (cfg_q),
        .data_q          (data_q),
        .status_q        (status_q),
        .chan_q          (chan_q)
    );

    assign access    = apb.psel && apb.penable;
    assign off       = apb.paddr - ADDR_W'(BASE_ADDR);
    assign in_range  = (apb.paddr >= ADDR_W'(BASE_ADDR)) && (off < ADDR_W'(4));
    assign bad       = !in_range || (apb.pwrite && off == ADDR_W'(OFF_STATUS));
    assign push_word = {off[TAG_W-1:0], apb.pwdata};
    assign irq       = status_q[STAT_RDV] && cfg_q[15];

    always_comb begin
        case (off[1:0])
            2'(OFF_CONFIG): rd_val = DATA_W'(cfg_q);
            2'(OFF_DATA):   rd_val = data_q;
            2'(OFF_STATUS): rd_val = DATA_W'(status_q);
            default:        rd_val = DATA_W'(chan_q);
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        prdata_n  = '0;
        inc_n     = 1'b0;
        wdata_n   = '0;
        clr_rdv   = 1'b0;
        clr_ovr   = 1'b0;
        case (state)
            ST_IDLE: if (access) begin
                if (bad) begin
                    state_n   = ST_RESP;
                    pready_n  = 1'b1;
                    pslverr_n = 1'b1;
                end else if (!apb.pwrite) begin
                    state_n  = ST_RESP;
                    pready_n = 1'b1;
                    prdata_n = rd_val;
                    clr_rdv  = (off == ADDR_W'(OFF_DATA));
                    clr_ovr  = (off == ADDR_W'(OFF_STATUS));
                end else if (!fifo_write_full) begin
                    state_n  = ST_RESP;
                    pready_n = 1'b1;
                    inc_n    = 1'b1;
                    wdata_n  = push_word;
                end else begin
                    state_n = ST_WAIT;
                    cnt_n   = '0;
                end
            end
            ST_WAIT: begin
                if (!fifo_write_full) begin
                    state_n  = ST_RESP;
                    pready_n = 1'b1;
                    inc_n    = 1'b1;
                    wdata_n  = push_word;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n   = ST_RESP;
                    pready_n  = 1'b1;
                    pslverr_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            apb.pready      <= 1'b0;
            apb.pslverr     <= 1'b0;
            apb.prdata      <= '0;
            fifo_write_inc  <= 1'b0;
            fifo_write_data <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            apb.pready      <= pready_n;
            apb.pslverr     <= pslverr_n;
            apb.prdata      <= prdata_n;
            fifo_write_inc  <= inc_n;
            fifo_write_data <= wdata_n;
        end
    end
endmodule
